// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg: shared types and constants for the hazard controller of the
// 5-stage pipeline (IF, ID, EX, MEM, WB).
//   fwd_sel_t    : EX operand source select (regfile / WB result / MEM ALU result)
//   halt_state_t : halt state machine encoding
//   HALT_WORD    : instruction word that triggers the halt sequence
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } halt_state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if: bundle between the pipeline and the hazard controller.
//   Pipeline -> controller : instr_f, rs_d/rt_d, rs_e/rt_e, write_reg_*,
//                            reg_write_*, mem_to_reg_e, mem_access_m,
//                            branch_taken_m
//   Controller -> pipeline : stall_f/d/e/m, flush_d/e/m, fwd_a_e/fwd_b_e, halted
//   HAZARD_PERF_CNT_EN     : adds perf_stall_cnt, perf_flush_cnt, perf_cycle_cnt
// Modports: master = pipeline side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  import cpu_pkg::*;

  logic [31:0]           instr_f;
  logic [REG_ADDR_W-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_ADDR_W-1:0] write_reg_e, write_reg_m, write_reg_w;
  logic                  reg_write_e, reg_write_m, reg_write_w;
  logic                  mem_to_reg_e, mem_access_m, branch_taken_m;

  logic                  stall_f, stall_d, stall_e, stall_m;
  logic                  flush_d, flush_e, flush_m;
  fwd_sel_t              fwd_a_e, fwd_b_e;
  logic                  halted;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           perf_stall_cnt, perf_flush_cnt, perf_cycle_cnt;

  modport master (
    output instr_f, rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_access_m, branch_taken_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, halted, perf_stall_cnt, perf_flush_cnt, perf_cycle_cnt
  );
  modport slave (
    input  instr_f, rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_access_m, branch_taken_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, halted, perf_stall_cnt, perf_flush_cnt, perf_cycle_cnt
  );
`else
  modport master (
    output instr_f, rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_access_m, branch_taken_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, halted
  );
  modport slave (
    input  instr_f, rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_access_m, branch_taken_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
           fwd_a_e, fwd_b_e, halted
  );
`endif

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select: combinational forwarding select for one EX source register.
//   src_i                        : EX source register index
//   write_reg_m_i, reg_write_m_i : MEM-stage destination and write enable
//   write_reg_w_i, reg_write_w_i : WB-stage destination and write enable
//   sel_o                        : FWD_MEM, FWD_WB or FWD_RF
// The MEM stage holds the younger result, so it wins when both stages match.
// Register 0 is hard-wired zero and is never forwarded.
// -----------------------------------------------------------------------------
module fwd_select
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] write_reg_m_i,
  input  logic [REG_ADDR_W-1:0] write_reg_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  output fwd_sel_t              sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && (write_reg_m_i != '0) && (write_reg_m_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_write_w_i && (write_reg_w_i != '0) && (write_reg_w_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl: hazard controller for the 5-stage pipeline (branches resolve in
// MEM). Produces EX forwarding selects, load-use stalls, branch flushes, the
// multi-cycle data-memory freeze and the halt/drain sequence.
//   CLOCK, RESET : clock and synchronous active-high reset
//   hz (slave)   : pipeline hazard info in, stall/flush/forward/halted out
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating perf counters).
// -----------------------------------------------------------------------------
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int          REG_ADDR_W   = 5,
  parameter int          MEM_LAT      = 1,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_INSTR   = HALT_WORD
) (
  input  logic          CLOCK,
  input  logic          RESET,
  hazard_ctrl_if.slave  hz
);

  localparam int             MCW        = $clog2(MEM_LAT) + 1;
  localparam logic [MCW-1:0] MEM_LAST   = MCW'(MEM_LAT - 1);
  localparam int             DCW        = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  halt_state_t    state_q, state_d;
  logic [MCW-1:0] mem_cnt_q, mem_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;

  fwd_sel_t fwd_a, fwd_b;
  logic     mem_stall, load_use, branch;
  logic     stall_f_c, stall_d_c, stall_e_c, stall_m_c;
  logic     flush_d_c, flush_e_c, flush_m_c, halted_c, br_flush_c;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src_i         (hz.rs_e),
    .write_reg_m_i (hz.write_reg_m),
    .write_reg_w_i (hz.write_reg_w),
    .reg_write_m_i (hz.reg_write_m),
    .reg_write_w_i (hz.reg_write_w),
    .sel_o         (fwd_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src_i         (hz.rt_e),
    .write_reg_m_i (hz.write_reg_m),
    .write_reg_w_i (hz.write_reg_w),
    .reg_write_m_i (hz.reg_write_m),
    .reg_write_w_i (hz.reg_write_w),
    .sel_o         (fwd_b)
  );

  // Access in MEM stalls until the counter reaches its final cycle.
  assign mem_stall = hz.mem_access_m && (mem_cnt_q != MEM_LAST);
  assign load_use  = hz.mem_to_reg_e && hz.reg_write_e && (hz.write_reg_e != '0) &&
                     ((hz.write_reg_e == hz.rs_d) || (hz.write_reg_e == hz.rt_d));
  assign branch    = hz.branch_taken_m;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    mem_cnt_d   = mem_stall ? (mem_cnt_q + MCW'(1)) : '0;
    stall_f_c   = 1'b0;
    stall_d_c   = 1'b0;
    stall_e_c   = 1'b0;
    stall_m_c   = 1'b0;
    flush_d_c   = 1'b0;
    flush_e_c   = 1'b0;
    flush_m_c   = 1'b0;
    halted_c    = 1'b0;
    br_flush_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        // Priority: memory freeze, then branch flush, then load-use bubble.
        if (mem_stall) begin
          {stall_f_c, stall_d_c, stall_e_c, stall_m_c} = 4'b1111;
        end else if (branch) begin
          {flush_d_c, flush_e_c, flush_m_c} = 3'b111;
          br_flush_c = 1'b1;
        end else if (load_use) begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          flush_e_c = 1'b1;
        end
        if ((hz.instr_f == HALT_INSTR) && !stall_f_c && !branch) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // PC frozen on the halt word; IF/ID refilled with bubbles.
        stall_f_c = 1'b1;
        flush_d_c = 1'b1;
        if (mem_stall) begin
          {stall_d_c, stall_e_c, stall_m_c} = 3'b111;
        end else if (branch) begin
          // Halt word was fetched down a mispredicted path: resume.
          {flush_e_c, flush_m_c} = 2'b11;
          br_flush_c = 1'b1;
          state_d    = RUN;
        end else begin
          if (drain_cnt_q == DCW'(1)) begin
            state_d = HALTED;
          end
          drain_cnt_d = drain_cnt_q - DCW'(1);
        end
      end
      HALTED: begin
        halted_c = 1'b1;
        {stall_f_c, stall_d_c, stall_e_c, stall_m_c} = 4'b1111;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= RUN;
      mem_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_cnt_q   <= mem_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Outputs forced low while reset is asserted so the pipeline sees no
  // spurious stall/flush/forward from stale inputs.
  assign hz.stall_f = stall_f_c && !RESET;
  assign hz.stall_d = stall_d_c && !RESET;
  assign hz.stall_e = stall_e_c && !RESET;
  assign hz.stall_m = stall_m_c && !RESET;
  assign hz.flush_d = flush_d_c && !RESET;
  assign hz.flush_e = flush_e_c && !RESET;
  assign hz.flush_m = flush_m_c && !RESET;
  assign hz.halted  = halted_c  && !RESET;
  assign hz.fwd_a_e = RESET ? FWD_RF : fwd_a;
  assign hz.fwd_b_e = RESET ? FWD_RF : fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_cycle_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_cycle_q <= '0;
    end else begin
      if ((state_q == RUN) && stall_f_c && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (br_flush_c && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
      if ((state_q != HALTED) && (perf_cycle_q != '1)) begin
        perf_cycle_q <= perf_cycle_q + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
  assign hz.perf_cycle_cnt = perf_cycle_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import cpu_pkg::*;

  localparam int RAW          = 5;
  localparam int MEM_LAT      = 3;
  localparam int DRAIN_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if #(.REG_ADDR_W(RAW)) hz ();

  hazard_ctrl #(
    .REG_ADDR_W   (RAW),
    .MEM_LAT      (MEM_LAT),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .HALT_INSTR   (32'hFFFF_FFFF)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  // Expected vector: {halted, fwd_a[1:0], fwd_b[1:0], sf, sd, se, sm, fd, fe, fm}
  typedef struct {
    logic [11:0] v;
    string       tag;
    bit          chk_perf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: operating mode, bubbles still to drain, and how many
  // cycles the current memory access has already been frozen.
  int m_mode  = 0;   // 0 running, 1 draining, 2 halted
  int m_left  = 0;
  int m_run   = 0;

  function automatic int ref_fwd(input int src);
    if (hz.reg_write_m && hz.write_reg_m != 0 && int'(hz.write_reg_m) == src) return 2;
    if (hz.reg_write_w && hz.write_reg_w != 0 && int'(hz.write_reg_w) == src) return 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    hz.instr_f = 32'h0;
    hz.rs_d = '0; hz.rt_d = '0; hz.rs_e = '0; hz.rt_e = '0;
    hz.write_reg_e = '0; hz.write_reg_m = '0; hz.write_reg_w = '0;
    hz.reg_write_e = 1'b0; hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0;
    hz.mem_to_reg_e = 1'b0; hz.mem_access_m = 1'b0; hz.branch_taken_m = 1'b0;
  endtask

  // Compute this cycle's expected outputs, push them, advance the model,
  // and move to just after the next rising edge.
  task automatic step(input string tag, input bit chk_perf = 1'b0);
    exp_t e;
    bit sf, sd, se, sm, fd, fe, fm, hl, memfrz, lu;
    int fa, fb;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fm = 0; hl = 0; fa = 0; fb = 0;
    memfrz = hz.mem_access_m && (m_run < MEM_LAT - 1);
    lu = hz.mem_to_reg_e && hz.reg_write_e && hz.write_reg_e != 0 &&
         (hz.write_reg_e == hz.rs_d || hz.write_reg_e == hz.rt_d);
    if (!rst) begin
      fa = ref_fwd(int'(hz.rs_e));
      fb = ref_fwd(int'(hz.rt_e));
      if (m_mode == 0) begin
        if (memfrz) begin sf = 1; sd = 1; se = 1; sm = 1; end
        else if (hz.branch_taken_m) begin fd = 1; fe = 1; fm = 1; end
        else if (lu) begin sf = 1; sd = 1; fe = 1; end
      end else if (m_mode == 1) begin
        sf = 1; fd = 1;
        if (memfrz) begin sd = 1; se = 1; sm = 1; end
        else if (hz.branch_taken_m) begin fe = 1; fm = 1; end
      end else begin
        hl = 1; sf = 1; sd = 1; se = 1; sm = 1;
      end
    end
    e.v = {hl, 2'(fa), 2'(fb), sf, sd, se, sm, fd, fe, fm};
    e.tag = tag;
    e.chk_perf = chk_perf;
    exp_q.push_back(e);
    if (rst) begin
      m_mode = 0; m_run = 0; m_left = 0;
    end else begin
      m_run = memfrz ? m_run + 1 : 0;
      if (m_mode == 0) begin
        if (hz.instr_f == 32'hFFFF_FFFF && !sf && !hz.branch_taken_m) begin
          m_mode = 1; m_left = DRAIN_CYCLES;
        end
      end else if (m_mode == 1 && !memfrz) begin
        if (hz.branch_taken_m) m_mode = 0;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle, one expected entry per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t x;
        logic [11:0] act;
        x = exp_q.pop_front();
        act = {hz.halted, hz.fwd_a_e, hz.fwd_b_e, hz.stall_f, hz.stall_d, hz.stall_e,
               hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_m};
        checks++;
        if (act === x.v) begin
          passed++;
          $display("[%0t] %s h/fa/fb/sfdem/fdem=%b ok", $time, x.tag, act);
        end else begin
          $display("FAIL %s: got h/fa/fb/sfdem/fdem=%b required %b", x.tag, act, x.v);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (x.chk_perf) begin
          checks++;
          if (hz.perf_stall_cnt == 0 && hz.perf_flush_cnt == 0 && hz.perf_cycle_cnt == 0)
            passed++;
          else
            $display("FAIL %s_perf: got %0d/%0d/%0d required 0/0/0", x.tag,
                     hz.perf_stall_cnt, hz.perf_flush_cnt, hz.perf_cycle_cnt);
        end
`endif
      end
    end
  end

  task automatic set_load_use();
    hz.mem_to_reg_e = 1'b1; hz.reg_write_e = 1'b1; hz.write_reg_e = 5'd5; hz.rs_d = 5'd5;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("idle_after_reset");

    // Forwarding
    clear_inputs();
    hz.reg_write_m = 1; hz.write_reg_m = 5'd3; hz.reg_write_w = 1; hz.write_reg_w = 5'd3; hz.rs_e = 5'd3;
    step("fwd_mem_beats_wb");
    clear_inputs();
    hz.reg_write_w = 1; hz.write_reg_w = 5'd3; hz.rt_e = 5'd3;
    step("fwd_wb_only");
    clear_inputs();
    hz.reg_write_m = 1; hz.write_reg_m = 5'd0; hz.rs_e = 5'd0;
    step("fwd_reg0");

    // Load-use
    clear_inputs(); set_load_use();
    step("load_use");
    clear_inputs();
    step("load_use_after");

    // Memory freeze with coincident load-use
    clear_inputs(); hz.mem_access_m = 1; set_load_use();
    for (int i = 0; i < MEM_LAT; i++) step($sformatf("mem_freeze%0d", i));
    clear_inputs();
    step("mem_after");

    // Branch + load-use
    clear_inputs(); set_load_use(); hz.branch_taken_m = 1;
    step("branch_lu");
    clear_inputs();
    step("branch_after");

    // Halt drain to HALTED
    hz.instr_f = 32'hFFFF_FFFF;
    step("halt_fetch");
    for (int i = 0; i < DRAIN_CYCLES + 2; i++) step($sformatf("halt_drain%0d", i));
    rst = 1; step("rst_halted_a");
    rst = 0; clear_inputs(); step("run_a");

    // Halt word on wrong path
    hz.instr_f = 32'hFFFF_FFFF;
    step("halt2_fetch");
    step("halt2_drain1");
    hz.branch_taken_m = 1;
    step("halt2_branch");
    clear_inputs();
    for (int i = 0; i < DRAIN_CYCLES + 1; i++) step($sformatf("halt2_run%0d", i));

    // Reach HALTED again and reset out of it
    hz.instr_f = 32'hFFFF_FFFF;
    for (int i = 0; i < DRAIN_CYCLES + 3; i++) step($sformatf("halt3_%0d", i));
    rst = 1; step("rst_halted_b");
    rst = 0; clear_inputs(); step("after_rst", 1'b1);

    // Randomised traffic
    for (int n = 0; n < 800; n++) begin
      hz.rs_d = RAW'($urandom_range(0, 7)); hz.rt_d = RAW'($urandom_range(0, 7));
      hz.rs_e = RAW'($urandom_range(0, 7)); hz.rt_e = RAW'($urandom_range(0, 7));
      hz.write_reg_e = RAW'($urandom_range(0, 7));
      hz.write_reg_m = RAW'($urandom_range(0, 7));
      hz.write_reg_w = RAW'($urandom_range(0, 7));
      hz.reg_write_e = 1'($urandom_range(0, 1));
      hz.reg_write_m = 1'($urandom_range(0, 1));
      hz.reg_write_w = 1'($urandom_range(0, 1));
      hz.mem_to_reg_e   = ($urandom_range(0, 9) < 4);
      hz.mem_access_m   = ($urandom_range(0, 9) < 5);
      hz.branch_taken_m = ($urandom_range(0, 19) < 2);
      hz.instr_f        = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom;
      rst = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      step($sformatf("rand%0d", n));
    end
    rst = 0;
    clear_inputs();

    // Let the monitor consume every pending expectation, bounded.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain_queue: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
